bus_sampler_n: RTL and testbench
================================

// Module: bus_sampler_n
// PURPOSE
//  Generalised RAM-bus front end: synchronises a WIDTH-bit bus and its clock to mclk,
//  detects bus_clk edges and majority-filters TAPS consecutive mclk samples per edge.
//  Adds both-edge mode, runt-clock rejection and a glitch counter, so one instance
//  covers both the positive-edge and the negative-edge capture paths of the tracer.
// PARAMETERS
//  WIDTH        44  bus bits sampled (address, data, byte lanes, control)
//  SYNC_STAGES   2  synchroniser flops on bus_in and bus_clk (>=2)
//  TAPS          3  samples per edge; odd, 1..7; output = per-bit majority
//  EDGE_MODE     0  0 = rising only, 1 = falling only, 2 = both
//  CNT_W        16  width of glitch_count
// PORTS
//  mclk          in   1      system clock
//  reset         in   1      asynchronous, active-high
//  bus_clk       in   1      raw bus clock, asynchronous to mclk
//  bus_in        in   WIDTH  raw bus signals, asynchronous to mclk
//  glitch_clear  in   1      synchronous clear of glitch_count
//  filter_out    out  WIDTH  last filtered sample
//  filter_strobe out  1      one-cycle pulse: filter_out updated
//  filter_edge   out  1      polarity of edge that produced filter_out (1 = rising)
//  glitch        out  1      one-cycle pulse with strobe: taps disagreed on >=1 bit
//  runt          out  1      one-cycle pulse: capture aborted, clock reverted early
//  glitch_count  out  CNT_W  saturating count of glitch pulses
// BEHAVIOUR
//  Reset: all outputs 0, sample latches 0, clock history 0, FSM IDLE. bus_clk high at
//  reset release is seen as a rising edge once it exits the synchroniser.
//  bus_in and bus_clk pass through identical SYNC_STAGES chains; clk_s, data_s aligned.
//  Edge = clk_s differs from its previous-cycle value; accepted only if EDGE_MODE permits.
//  FSM IDLE: on accepted edge latch data_s as sample 0, pol <= new clk_s level, k <= 1,
//    go CAPT. TAPS=1: skip CAPT, register data_s directly (as final step below).
//  FSM CAPT: if clk_s != pol -> runt pulse, discard samples, go IDLE; if that same
//    transition is itself an accepted edge, start a new capture this cycle (sample 0).
//    Else if k < TAPS-1: latch data_s as sample k, k <= k+1.
//    Else (k == TAPS-1): filter_out <= bitwise majority(samples 0..TAPS-2, data_s),
//    filter_edge <= pol, filter_strobe <= 1, glitch <= any bit not unanimous; go IDLE.
//  Latency: strobe high TAPS cycles after the cycle the edge appears on clk_s.
//  filter_out holds between strobes; strobe/glitch/runt are single-cycle pulses.
//  glitch_count: +1 per glitch pulse, saturates at all-ones, never wraps.
//  glitch_clear wins over a same-cycle increment: count becomes 0.
//  Edges arriving while CAPT at a non-reverting level are impossible (level = pol).
//  Reset mid-capture: capture dropped, no strobe, state as above.
// TESTING
//  1 Rising edge, bus_in=0x0ABC_DEF0123 stable 6 mclk, TAPS=3, mode 0 -> one strobe
//    3 cycles after edge on clk_s, filter_out=0x0ABC_DEF0123, edge=1, glitch=0.
//  2 Bit 0 flipped on sample 1 only -> filter_out bit 0 = stable value, glitch=1,
//    glitch_count 0 -> 1.
//  3 bus_clk high for 1 mclk only (TAPS=3) -> runt=1, no strobe, filter_out unchanged.
//  4 EDGE_MODE=2, 8-mclk-period clock, data changes each half -> strobes alternate
//    filter_edge 1,0,1,0 with matching data; EDGE_MODE=0 on same stimulus -> edge=1 only.
//  5 CNT_W=2, five glitching edges -> count 1,2,3,3,3; glitch_clear on 5th -> 0.
//  6 Assert reset during CAPT -> all outputs 0 immediately, no strobe after release.

Source files
------------

// File: rtl/bus_sampler_n.sv
// rtl/bus_sampler_n.sv - synchronising, edge-triggered, majority-filtering bus sampler
//
// Purpose: brings an asynchronous WIDTH-bit bus and its clock into the mclk domain,
// detects bus_clk edges, and majority-votes TAPS consecutive samples per accepted edge.
// A clock that reverts before all TAPS samples are taken aborts the capture (runt).
//
// Ports:
//   mclk          in   system clock
//   reset         in   asynchronous, active-high reset
//   bus_clk       in   raw bus clock (asynchronous)
//   bus_in        in   raw bus bits (asynchronous)
//   glitch_clear  in   synchronous clear of glitch_count (wins over increment)
//   filter_out    out  last filtered sample, held between strobes
//   filter_strobe out  one-cycle pulse when filter_out updates
//   filter_edge   out  polarity of the edge behind filter_out (1 = rising)
//   glitch        out  one-cycle pulse with strobe: taps disagreed on some bit
//   runt          out  one-cycle pulse: capture aborted by an early clock revert
//   glitch_count  out  saturating count of glitch pulses
module bus_sampler_n #(
  parameter int WIDTH       = 44,
  parameter int SYNC_STAGES = 2,
  parameter int TAPS        = 3,
  parameter int EDGE_MODE   = 0,
  parameter int CNT_W       = 16
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             bus_clk,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             glitch_clear,
  output logic [WIDTH-1:0] filter_out,
  output logic             filter_strobe,
  output logic             filter_edge,
  output logic             glitch,
  output logic             runt,
  output logic [CNT_W-1:0] glitch_count
);

  // Samples held before the final tap; the final tap is taken straight from data_s.
  localparam int NS = (TAPS > 1) ? TAPS - 1 : 1;
  localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic {IDLE, CAPT} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [WIDTH-1:0]       data_sync_q [SYNC_STAGES];
  logic                   clk_prev_q;

  state_t           state_q, state_d;
  logic             pol_q, pol_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] samp_q [NS];
  logic [WIDTH-1:0] samp_d [NS];

  logic [WIDTH-1:0] filter_out_q, filter_out_d;
  logic             filter_edge_q, filter_edge_d;
  logic             strobe_q, strobe_d;
  logic             glitch_q, glitch_d;
  logic             runt_q, runt_d;
  logic [CNT_W-1:0] glitch_count_q, glitch_count_d;

  logic             clk_s;
  logic [WIDTH-1:0] data_s;
  logic             edge_ok;
  logic [WIDTH-1:0] maj;
  logic             any_glitch;
  logic             start, finish;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  // A level change on the synchronised clock, filtered by the configured polarity.
  assign edge_ok = (clk_s != clk_prev_q) &&
                   ((EDGE_MODE == 2) || (EDGE_MODE == 0 && clk_s) || (EDGE_MODE == 1 && !clk_s));

  // Per-bit vote over the stored samples plus the current data_s tap.
  always_comb begin
    maj        = '0;
    any_glitch = 1'b0;
    for (int b = 0; b < WIDTH; b++) begin
      int ones;
      ones = int'(data_s[b]);
      for (int j = 0; j < TAPS - 1; j++) ones += int'(samp_q[j][b]);
      maj[b] = (2 * ones > TAPS);
      if (ones != 0 && ones != TAPS) any_glitch = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    pol_d         = pol_q;
    k_d           = k_q;
    samp_d        = samp_q;
    filter_out_d  = filter_out_q;
    filter_edge_d = filter_edge_q;
    strobe_d      = 1'b0;
    glitch_d      = 1'b0;
    runt_d        = 1'b0;
    start         = 1'b0;
    finish        = 1'b0;

    case (state_q)
      IDLE: start = edge_ok;
      CAPT: begin
        if (clk_s != pol_q) begin
          // Clock reverted early; the revert may itself open a new capture.
          runt_d  = 1'b1;
          state_d = IDLE;
          start   = edge_ok;
        end else if (k_q < KW'(TAPS - 1)) begin
          for (int j = 0; j < NS; j++)
            if (k_q == KW'(j)) samp_d[j] = data_s;
          k_d = k_q + 1'b1;
        end else begin
          finish = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      pol_d = clk_s;
      if (TAPS == 1) begin
        finish = 1'b1;
      end else begin
        samp_d[0] = data_s;
        k_d       = KW'(1);
        state_d   = CAPT;
      end
    end

    if (finish) begin
      filter_out_d  = maj;
      filter_edge_d = pol_d;
      strobe_d      = 1'b1;
      glitch_d      = any_glitch;
      state_d       = IDLE;
    end

    if (glitch_clear)
      glitch_count_d = '0;
    else if (glitch_d && !(&glitch_count_q))
      glitch_count_d = glitch_count_q + 1'b1;
    else
      glitch_count_d = glitch_count_q;
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      clk_sync_q     <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
      clk_prev_q     <= 1'b0;
      state_q        <= IDLE;
      pol_q          <= 1'b0;
      k_q            <= '0;
      for (int i = 0; i < NS; i++) samp_q[i] <= '0;
      filter_out_q   <= '0;
      filter_edge_q  <= 1'b0;
      strobe_q       <= 1'b0;
      glitch_q       <= 1'b0;
      runt_q         <= 1'b0;
      glitch_count_q <= '0;
    end else begin
      clk_sync_q     <= {clk_sync_q[SYNC_STAGES-2:0], bus_clk};
      for (int i = SYNC_STAGES - 1; i > 0; i--) data_sync_q[i] <= data_sync_q[i-1];
      data_sync_q[0] <= bus_in;
      clk_prev_q     <= clk_s;
      state_q        <= state_d;
      pol_q          <= pol_d;
      k_q            <= k_d;
      samp_q         <= samp_d;
      filter_out_q   <= filter_out_d;
      filter_edge_q  <= filter_edge_d;
      strobe_q       <= strobe_d;
      glitch_q       <= glitch_d;
      runt_q         <= runt_d;
      glitch_count_q <= glitch_count_d;
    end
  end

  assign filter_out    = filter_out_q;
  assign filter_strobe = strobe_q;
  assign filter_edge   = filter_edge_q;
  assign glitch        = glitch_q;
  assign runt          = runt_q;
  assign glitch_count  = glitch_count_q;

endmodule

// File: tb/tb_bus_sampler_n.sv
// tb/tb_bus_sampler_n.sv - bench for bus_sampler_n across several parameter sets
module tb_bus_sampler_n;
  localparam int W  = 44;
  localparam int NI = 5;

  logic         mclk = 1'b0;
  logic         reset = 1'b1;
  logic         bus_clk = 1'b0;
  logic [W-1:0] bus_in = '0;
  logic         glitch_clear = 1'b0;

  always #5 mclk = ~mclk;

  logic [W-1:0] fo [NI];
  logic         fs [NI];
  logic         fe [NI];
  logic         gl [NI];
  logic         rn [NI];
  logic [15:0]  gc0, gc1, gc3, gc4;
  logic [1:0]   gc2;

  bus_sampler_n #(.WIDTH(W), .SYNC_STAGES(2), .TAPS(3), .EDGE_MODE(0), .CNT_W(16)) u0 (
    .mclk(mclk), .reset(reset), .bus_clk(bus_clk), .bus_in(bus_in), .glitch_clear(glitch_clear),
    .filter_out(fo[0]), .filter_strobe(fs[0]), .filter_edge(fe[0]), .glitch(gl[0]), .runt(rn[0]),
    .glitch_count(gc0));
  bus_sampler_n #(.WIDTH(W), .SYNC_STAGES(2), .TAPS(3), .EDGE_MODE(2), .CNT_W(16)) u1 (
    .mclk(mclk), .reset(reset), .bus_clk(bus_clk), .bus_in(bus_in), .glitch_clear(glitch_clear),
    .filter_out(fo[1]), .filter_strobe(fs[1]), .filter_edge(fe[1]), .glitch(gl[1]), .runt(rn[1]),
    .glitch_count(gc1));
  bus_sampler_n #(.WIDTH(W), .SYNC_STAGES(2), .TAPS(3), .EDGE_MODE(0), .CNT_W(2)) u2 (
    .mclk(mclk), .reset(reset), .bus_clk(bus_clk), .bus_in(bus_in), .glitch_clear(glitch_clear),
    .filter_out(fo[2]), .filter_strobe(fs[2]), .filter_edge(fe[2]), .glitch(gl[2]), .runt(rn[2]),
    .glitch_count(gc2));
  bus_sampler_n #(.WIDTH(W), .SYNC_STAGES(2), .TAPS(1), .EDGE_MODE(1), .CNT_W(16)) u3 (
    .mclk(mclk), .reset(reset), .bus_clk(bus_clk), .bus_in(bus_in), .glitch_clear(glitch_clear),
    .filter_out(fo[3]), .filter_strobe(fs[3]), .filter_edge(fe[3]), .glitch(gl[3]), .runt(rn[3]),
    .glitch_count(gc3));
  bus_sampler_n #(.WIDTH(W), .SYNC_STAGES(3), .TAPS(5), .EDGE_MODE(2), .CNT_W(16)) u4 (
    .mclk(mclk), .reset(reset), .bus_clk(bus_clk), .bus_in(bus_in), .glitch_clear(glitch_clear),
    .filter_out(fo[4]), .filter_strobe(fs[4]), .filter_edge(fe[4]), .glitch(gl[4]), .runt(rn[4]),
    .glitch_count(gc4));

  function automatic int taps_of(input int i);
    case (i) 3: return 1; 4: return 5; default: return 3; endcase
  endfunction
  function automatic int mode_of(input int i);
    case (i) 1: return 2; 3: return 1; 4: return 2; default: return 0; endcase
  endfunction
  function automatic int sync_of(input int i);
    return (i == 4) ? 3 : 2;
  endfunction
  function automatic int cw_of(input int i);
    return (i == 2) ? 2 : 16;
  endfunction
  function automatic logic [15:0] obs_gc(input int i);
    case (i)
      0: return gc0;
      1: return gc1;
      2: return {14'b0, gc2};
      3: return gc3;
      default: return gc4;
    endcase
  endfunction
  function automatic logic [W-1:0] rnd_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: synchronisers are plain delay lines, a capture is a buffer of
  // samples taken while the synchronised clock holds its new level.
  logic         mp_c [NI][4];
  logic [W-1:0] mp_d [NI][4];
  logic         m_prev [NI];
  logic         m_cap  [NI];
  logic         m_pol  [NI];
  logic [W-1:0] m_buf  [NI][8];
  int           m_n    [NI];
  logic [W-1:0] e_fo [NI];
  logic         e_fe [NI], e_fs [NI], e_gl [NI], e_rn [NI];
  int           e_gc [NI];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int j = 0; j < 4; j++) begin mp_c[i][j] = 1'b0; mp_d[i][j] = '0; end
      m_prev[i] = 1'b0; m_cap[i] = 1'b0; m_pol[i] = 1'b0; m_n[i] = 0;
      for (int j = 0; j < 8; j++) m_buf[i][j] = '0;
      e_fo[i] = '0; e_fe[i] = 1'b0; e_fs[i] = 1'b0; e_gl[i] = 1'b0; e_rn[i] = 1'b0; e_gc[i] = 0;
    end
  endtask

  task automatic finish_cap(input int i);
    int t, ones;
    logic [W-1:0] v;
    logic g;
    t = taps_of(i); v = '0; g = 1'b0;
    for (int b = 0; b < W; b++) begin
      ones = 0;
      for (int j = 0; j < t; j++) ones += int'(m_buf[i][j][b]);
      v[b] = (2 * ones > t);
      if (ones != 0 && ones != t) g = 1'b1;
    end
    e_fo[i] = v; e_fe[i] = m_pol[i]; e_fs[i] = 1'b1; e_gl[i] = g; m_cap[i] = 1'b0;
  endtask

  task automatic model_step(input int i);
    int t, md, s, mx;
    logic cs, acc, start;
    logic [W-1:0] ds;
    t = taps_of(i); md = mode_of(i); s = sync_of(i);
    cs = mp_c[i][s-1]; ds = mp_d[i][s-1];
    acc = (cs != m_prev[i]) && (md == 2 || (md == 0 && cs) || (md == 1 && !cs));
    e_fs[i] = 1'b0; e_gl[i] = 1'b0; e_rn[i] = 1'b0; start = 1'b0;
    if (m_cap[i]) begin
      if (cs != m_pol[i]) begin
        e_rn[i] = 1'b1; m_cap[i] = 1'b0; start = acc;
      end else begin
        m_buf[i][m_n[i]] = ds; m_n[i]++;
        if (m_n[i] == t) finish_cap(i);
      end
    end else begin
      start = acc;
    end
    if (start) begin
      m_cap[i] = 1'b1; m_pol[i] = cs; m_buf[i][0] = ds; m_n[i] = 1;
      if (t == 1) finish_cap(i);
    end
    mx = (1 << cw_of(i)) - 1;
    if (glitch_clear) e_gc[i] = 0;
    else if (e_gl[i] && e_gc[i] < mx) e_gc[i]++;
    for (int j = s - 1; j > 0; j--) begin mp_c[i][j] = mp_c[i][j-1]; mp_d[i][j] = mp_d[i][j-1]; end
    mp_c[i][0] = bus_clk; mp_d[i][0] = bus_in;
    m_prev[i] = cs;
  endtask

  initial begin
    forever begin
      @(posedge mclk or posedge reset);
      if (reset) model_reset();
      else for (int i = 0; i < NI; i++) model_step(i);
    end
  end

  logic chk_en = 1'b0;
  int   n_stb [NI];
  int   n_rnt [NI];

  initial begin
    for (int i = 0; i < NI; i++) begin n_stb[i] = 0; n_rnt[i] = 0; end
    forever begin
      @(negedge mclk);
      if (chk_en) begin
        for (int i = 0; i < NI; i++) begin
          check($sformatf("u%0d strobe", i), 64'(fs[i]), 64'(e_fs[i]));
          check($sformatf("u%0d runt", i),   64'(rn[i]), 64'(e_rn[i]));
          check($sformatf("u%0d glitch", i), 64'(gl[i]), 64'(e_gl[i]));
          check($sformatf("u%0d data", i),   64'(fo[i]), 64'(e_fo[i]));
          check($sformatf("u%0d edge", i),   64'(fe[i]), 64'(e_fe[i]));
          check($sformatf("u%0d count", i),  64'(obs_gc(i)), 64'(e_gc[i]));
          if (fs[i] === 1'b1) n_stb[i]++;
          if (rn[i] === 1'b1) n_rnt[i]++;
        end
      end
    end
  end

  task automatic drive(input logic c, input logic [W-1:0] d, input int n);
    bus_clk = c; bus_in = d;
    repeat (n) @(negedge mclk);
  endtask

  task automatic glitchy_edge(input logic [W-1:0] d);
    drive(1'b1, d, 1);
    drive(1'b1, d ^ 44'h1, 1);
    drive(1'b1, d, 5);
    drive(1'b0, d, 5);
  endtask

  logic [W-1:0] d1, d2, dh;
  int s0, s1, r0, hold;
  int exp_cnt [5] = '{1, 2, 3, 3, 0};

  initial begin
    @(posedge mclk);
    #1 chk_en = 1'b1;
    check("reset data", 64'(fo[0]), 64'h0);
    check("reset strobe", 64'(fs[0]), 64'h0);
    check("reset count", 64'(obs_gc(0)), 64'h0);
    @(negedge mclk);
    #2 reset = 1'b0;
    drive(1'b0, '0, 6);

    d1 = 44'h0ABCDEF0123;
    drive(1'b1, d1, 6);
    drive(1'b0, d1, 6);
    check("stable data", 64'(fo[0]), 64'(d1));
    check("stable edge", 64'(fe[0]), 64'h1);
    check("stable count", 64'(obs_gc(0)), 64'h0);

    d2 = rnd_word();
    glitchy_edge(d2);
    drive(1'b0, d2, 2);
    check("vote data", 64'(fo[0]), 64'(d2));
    check("vote count", 64'(obs_gc(0)), 64'h1);

    r0 = n_rnt[0]; s0 = n_stb[0];
    drive(1'b1, ~d2, 1);
    drive(1'b0, ~d2, 6);
    check("runt pulses", 64'(n_rnt[0] - r0), 64'h1);
    check("runt no strobe", 64'(n_stb[0] - s0), 64'h0);
    check("runt data held", 64'(fo[0]), 64'(d2));

    s0 = n_stb[0]; s1 = n_stb[1];
    for (int h = 0; h < 4; h++) drive((h % 2) == 0, rnd_word(), 4);
    drive(1'b0, bus_in, 6);
    check("both-edge strobes", 64'(n_stb[1] - s1), 64'h4);
    check("rise-only strobes", 64'(n_stb[0] - s0), 64'h2);
    check("both-edge last pol", 64'(fe[1]), 64'h0);

    glitch_clear = 1'b1;
    @(negedge mclk);
    glitch_clear = 1'b0;
    for (int e = 0; e < 5; e++) begin
      if (e == 4) glitch_clear = 1'b1;
      glitchy_edge(rnd_word());
      glitch_clear = 1'b0;
      check($sformatf("sat count %0d", e), 64'(obs_gc(2)), 64'(exp_cnt[e]));
    end

    drive(1'b0, '0, 6);
    s0 = n_stb[0];
    drive(1'b1, rnd_word(), 3);
    #2 reset = 1'b1;
    #1;
    check("midreset data", 64'(fo[0]), 64'h0);
    check("midreset strobe", 64'(fs[0]), 64'h0);
    check("midreset edge", 64'(fe[0]), 64'h0);
    check("midreset glitch", 64'(gl[0]), 64'h0);
    check("midreset runt", 64'(rn[0]), 64'h0);
    check("midreset count", 64'(obs_gc(0)), 64'h0);
    bus_clk = 1'b0;
    repeat (2) @(negedge mclk);
    #2 reset = 1'b0;
    repeat (10) @(negedge mclk);
    check("post-reset strobe", 64'(n_stb[0] - s0), 64'h0);

    hold = 0;
    dh = rnd_word();
    for (int c = 0; c < 3000; c++) begin
      int r;
      if (hold == 0) begin bus_clk = ~bus_clk; hold = $urandom_range(1, 7); end
      hold--;
      r = $urandom_range(0, 9);
      if (r < 2) dh = rnd_word();
      else if (r == 2) dh[$urandom_range(0, W - 1)] ^= 1'b1;
      bus_in = dh;
      glitch_clear = ($urandom_range(0, 99) == 0);
      @(negedge mclk);
    end
    glitch_clear = 1'b0;
    drive(1'b0, dh, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
